// File: rtl/base_n_digit_add.sv
// Single-digit adder in radix BASE.
// Adds two DW-bit digits plus a carry-in, wrapping at BASE, and flags any
// operand digit that is not a legal digit of the radix.
//   a, b    : operand digits
//   cin     : carry in (0 or 1)
//   digit   : (a + b + cin) mod BASE, valid when both operands are legal
//   cout    : 1 when a + b + cin >= BASE
//   invalid : 1 when a >= BASE or b >= BASE
module base_n_digit_add #(
    parameter int unsigned BASE = 14,
    parameter int unsigned DW   = 4
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    output logic [DW-1:0] digit,
    output logic          cout,
    output logic          invalid
);

    // One extra bit so that BASE == 2**DW is representable.
    localparam logic [DW:0] BaseW = (DW+1)'(BASE);

    logic [DW:0] t;
    logic [DW:0] t_wrapped;

    assign t         = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    assign t_wrapped = t - BaseW;
    assign cout      = (t >= BaseW);
    assign digit     = cout ? t_wrapped[DW-1:0] : t[DW-1:0];
    assign invalid   = ({1'b0, a} >= BaseW) || ({1'b0, b} >= BaseW);

endmodule

// File: rtl/base_n_serial_adder.sv
// Digit-serial adder for two unsigned DIGITS-digit numbers in radix BASE.
// One digit pair is summed per clock, least significant first, after a start
// request in IDLE. The (DIGITS+1)-digit result is registered and announced by
// a one-cycle done pulse; operands holding an illegal digit are rejected
// immediately with err set and sum cleared.
//   CLOCK_50 : clock, rising edge
//   RESET    : asynchronous active-high reset
//   start    : add request, sampled only in IDLE
//   a_digits : operand A, digit i at [i*DW +: DW]
//   b_digits : operand B, same packing
//   busy     : addition in progress
//   done     : one-cycle pulse when sum/err are updated
//   err      : last accepted operand set held a digit >= BASE
//   sum      : result digits, top digit is the final carry
module base_n_serial_adder #(
    parameter int unsigned BASE   = 14,
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DW     = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [DIGITS*DW-1:0]     a_digits,
    input  logic [DIGITS*DW-1:0]     b_digits,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [(DIGITS+1)*DW-1:0] sum
);

    localparam int unsigned       IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned       SW      = (DIGITS + 1) * DW;
    localparam logic [IW-1:0]     LastIdx = IW'(DIGITS - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   a_q    [DIGITS];
    logic [DW-1:0]   a_d    [DIGITS];
    logic [DW-1:0]   b_q    [DIGITS];
    logic [DW-1:0]   b_d    [DIGITS];
    logic [DW-1:0]   work_q [DIGITS];
    logic [DW-1:0]   work_d [DIGITS];
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [SW-1:0]   sum_q, sum_d;

    // Validity scan over the raw inputs so a bad operand set is caught at the
    // start edge itself. Only the invalid flag of these adders is used.
    logic [DIGITS-1:0] inv_vec;
    logic [DW-1:0]     chk_digit [DIGITS];
    logic [DIGITS-1:0] chk_cout;
    logic              any_invalid;

    for (genvar g = 0; g < DIGITS; g++) begin : g_chk
        base_n_digit_add #(
            .BASE (BASE),
            .DW   (DW)
        ) u_chk (
            .a       (a_digits[g*DW +: DW]),
            .b       (b_digits[g*DW +: DW]),
            .cin     (1'b0),
            .digit   (chk_digit[g]),
            .cout    (chk_cout[g]),
            .invalid (inv_vec[g])
        );
    end

    logic unused_chk;
    always_comb begin
        unused_chk = ^chk_cout;
        for (int i = 0; i < DIGITS; i++) begin
            unused_chk = unused_chk ^ (^chk_digit[i]);
        end
    end

    assign any_invalid = |inv_vec;

    // RUN datapath: one digit pair per cycle.
    logic [DW-1:0] add_digit;
    logic          add_cout;
    logic          add_invalid;

    base_n_digit_add #(
        .BASE (BASE),
        .DW   (DW)
    ) u_add (
        .a       (a_q[idx_q]),
        .b       (b_q[idx_q]),
        .cin     (carry_q),
        .digit   (add_digit),
        .cout    (add_cout),
        .invalid (add_invalid)
    );

    logic unused_add;
    assign unused_add = add_invalid;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        work_d  = work_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        err_d   = err_q;
        sum_d   = sum_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        a_d[i] = a_digits[i*DW +: DW];
                        b_d[i] = b_digits[i*DW +: DW];
                    end
                    if (any_invalid) begin
                        err_d  = 1'b1;
                        sum_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        carry_d = 1'b0;
                        idx_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                work_d[idx_q] = add_digit;
                carry_d       = add_cout;
                idx_d         = idx_q + IW'(1);
                if (idx_q == LastIdx) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        sum_d[i*DW +: DW] = work_d[i];
                    end
                    sum_d[DIGITS*DW +: DW] = DW'(add_cout);
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            for (int i = 0; i < DIGITS; i++) begin
                a_q[i]    <= '0;
                b_q[i]    <= '0;
                work_q[i] <= '0;
            end
            idx_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            work_q  <= work_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            err_q   <= err_d;
            sum_q   <= sum_d;
        end
    end

    assign busy = (state_q == StRun);
    assign done = done_q;
    assign err  = err_q;
    assign sum  = sum_q;

endmodule

// File: doc/base_n_serial_adder.md
Name: base_n_serial_adder

Overview:
Digit-serial adder for two unsigned multi-digit numbers in an arbitrary radix BASE (default 14, digits 0..13). It processes one digit pair per clock, LSB first, using a start/done handshake, and presents a registered (DIGITS+1)-digit result. It sits between the switch/operand capture logic and the per-digit 7-segment decoders on the board top level. It generalises the fixed two-digit combinational base-14 adder to any digit count and radix, and adds sequential operation and input validation.

Parameters:
BASE, 14, radix; legal range 2..2**DW.
DIGITS, 4, number of operand digits; legal range 1..16.
DW, 4, bits per digit; must satisfy 2**DW >= BASE.

Ports:
CLOCK_50  in  1  system clock; all state changes on the rising edge.
RESET  in  1  asynchronous, active-high reset.
start  in  1  request to add; sampled only in IDLE.
a_digits  in  DIGITS*DW  operand A; digit i at [i*DW +: DW], digit 0 is least significant.
b_digits  in  DIGITS*DW  operand B; same packing as a_digits.
busy  out  1  high while an addition is in progress.
done  out  1  one-cycle pulse when sum/err are updated.
err  out  1  high if the last accepted operand set held a digit >= BASE.
sum  out  (DIGITS+1)*DW  result digits; the top digit is the final carry (0 or 1).

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE, busy=0, done=0, err=0, sum=0, carry=0, index=0. Any partial result is discarded.
- States: IDLE, RUN.
- IDLE, start=1 at edge E0:
  - Latch a_digits and b_digits into internal registers.
  - Check every digit of both operands against BASE.
  - If any digit >= BASE: err=1, sum=0, done=1 for one cycle, stay in IDLE, busy remains 0.
  - Otherwise: err=0, carry=0, index=0, busy=1, go to RUN.
- RUN, each edge: t = a[index] + b[index] + carry, computed DW+1 bits wide.
  - If t >= BASE: digit = t - BASE and carry=1.
  - Otherwise: digit = t and carry=0.
  - Write the digit into internal working register slot [index], then increment index.
- RUN at index == DIGITS-1 (edge E_DIGITS):
  - Process the final digit.
  - Load sum from the working register, with the top digit = final carry.
  - done=1 for one cycle, busy=0, go to IDLE.
- Latency: done is high in the cycle after edge E_DIGITS, i.e. DIGITS clocks after the start edge. Throughput is one addition per DIGITS+1 cycles (start re-accepted the cycle after done).
- start while busy: ignored. Inputs changing during RUN: no effect, because operands are latched.
- start held high continuously: a new operation begins on the first IDLE edge after completion.
- sum and err hold their values until the next completion, or until RESET.
- done never asserts without a preceding accepted start.
- BASE == 2**DW: the invalid check never fires. The carry condition is still t >= BASE.

Decomposition:
- Shared package: none required. Digit packing helpers and the IDLE/RUN state encoding live as localparams in the module.
- One sub-module: base_n_digit_add.
  - Combinational.
  - Inputs: a, b, cin.
  - Outputs: digit, cout, and invalid = (a >= BASE) || (b >= BASE).
  - Parameters: BASE, DW.
  - Reused by the combinational validity scan and the RUN datapath.

Test Plan:
1. Carry chain. Defaults; A digits (3..0)=0,0,13,13; B=0,0,0,1; pulse start -> done exactly 4 cycles after the start edge; sum digits (4..0)=0,0,1,0,0; err=0.
2. Maximum operands. A=B=13,13,13,13 -> sum=1,13,13,13,12; top digit=1; err=0.
3. Invalid digit. A digit1=14, everything else 0 -> done the cycle after the start edge; err=1; sum=0; busy never asserted. A following valid start (A=5, B=4) -> err clears; sum=0,0,0,0,9.
4. Start while busy. Start, then start again 2 cycles later with different operands -> only one done pulse; sum reflects the first operand set. With start held high, a second done follows 5 cycles after the first.
5. Reset mid-operation. Assert RESET 2 cycles into RUN, asynchronously between edges -> busy/done/err/sum go to 0 immediately; no done pulse afterwards until a new start.
6. Parameter sweep. BASE=10, DIGITS=2: 99+1 -> 1,0,0. BASE=16, DW=4, DIGITS=3: F,F,F + 0,0,1 -> 1,0,0,0; err never set.
